// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared configuration helpers for segmented carry-skip adders
package adder_pkg;

    function automatic bit csa_cfg_legal(input int width, input int blk, input int stages);
        return (width > 0) && (blk > 0) && (stages > 0) && ((width % (blk * stages)) == 0);
    endfunction

    // Divisors are guarded so an illegal configuration still elaborates far
    // enough to report the legality error instead of a divide-by-zero.
    function automatic int calc_seg_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic int calc_nblk(input int width, input int blk, input int stages);
        return (blk > 0) ? (calc_seg_w(width, stages) / blk) : 1;
    endfunction

endpackage

// File: rtl/csa_skip_block.sv
// rtl/csa_skip_block.sv - BLK-bit ripple block with carry-skip bypass mux
module csa_skip_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK:0]   c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s    = p ^ c[BLK-1:0];
        // Full propagate: the ripple result equals cin, take the short path.
        cout = (&p) ? cin : c[BLK];
    end

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// rtl/pipelined_carry_skip_adder.sv - segmented carry-skip adder/subtractor, one segment per pipeline stage
module pipelined_carry_skip_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SEG_W = calc_seg_w(WIDTH, STAGES);
    localparam int NBLK  = calc_nblk(WIDTH, BLK, STAGES);

    if (!csa_cfg_legal(WIDTH, BLK, STAGES)) begin : g_illegal_cfg
        $error("pipelined_carry_skip_adder: WIDTH must be a multiple of BLK*STAGES");
    end

    // Per-stage state, flattened: stage k occupies slice [k*WIDTH +: WIDTH].
    logic [STAGES*WIDTH-1:0] sum_d, sum_q;
    logic [STAGES*WIDTH-1:0] opa_d, opa_q;
    logic [STAGES*WIDTH-1:0] opb_d, opb_q;
    logic [STAGES-1:0]       carry_d, carry_q;
    logic [STAGES-1:0]       vld_d, vld_q;
    logic                    ovf_d, ovf_q;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             advance;

    // Subtraction is folded into operand B at entry, so later stages never need sub.
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub ? 1'b1 : cin;
    end

    assign out_valid = vld_q[STAGES-1];
    assign in_ready  = ~out_valid | out_ready;
    assign advance   = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] in_a;
        logic [WIDTH-1:0] in_b;
        logic [WIDTH-1:0] in_s;
        logic             in_c;
        logic             in_v;
        logic [SEG_W-1:0] seg_s;
        logic [WIDTH-1:0] s_full;
        logic             seg_cout;

        if (k == 0) begin : g_first
            assign in_a = a;
            assign in_b = b_eff;
            assign in_s = '0;
            assign in_c = c0;
            assign in_v = in_valid;
        end else begin : g_next
            assign in_a = opa_q[(k-1)*WIDTH +: WIDTH];
            assign in_b = opb_q[(k-1)*WIDTH +: WIDTH];
            assign in_s = sum_q[(k-1)*WIDTH +: WIDTH];
            assign in_c = carry_q[k-1];
            assign in_v = vld_q[k-1];
        end

        for (genvar j = 0; j < NBLK; j++) begin : g_blk
            logic blk_cin;
            logic blk_cout;

            if (j == 0) begin : g_cin_seg
                assign blk_cin = in_c;
            end else begin : g_cin_chain
                assign blk_cin = g_blk[j-1].blk_cout;
            end

            csa_skip_block #(
                .BLK (BLK)
            ) u_blk (
                .a    (in_a[k*SEG_W + j*BLK +: BLK]),
                .b    (in_b[k*SEG_W + j*BLK +: BLK]),
                .cin  (blk_cin),
                .s    (seg_s[j*BLK +: BLK]),
                .cout (blk_cout)
            );
        end

        assign seg_cout = g_blk[NBLK-1].blk_cout;

        always_comb begin
            s_full                      = in_s;
            s_full[k*SEG_W +: SEG_W]    = seg_s;
        end

        assign sum_d[k*WIDTH +: WIDTH] = s_full;
        assign opa_d[k*WIDTH +: WIDTH] = in_a;
        assign opb_d[k*WIDTH +: WIDTH] = in_b;
        assign carry_d[k]              = seg_cout;
        assign vld_d[k]                = in_v;

        if (k == STAGES - 1) begin : g_last
            // Carry into the MSB is recovered from its sum bit: c = a ^ b ^ s.
            assign ovf_d = in_a[WIDTH-1] ^ in_b[WIDTH-1] ^ s_full[WIDTH-1] ^ seg_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= '0;
            vld_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (advance) begin
            sum_q   <= sum_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
        end
    end

    // Already-consumed operand bits are carried along for uniformity and trimmed in synthesis.
    logic unused_ok;
    assign unused_ok = ^{opa_q, opb_q};

    assign sum  = sum_q[(STAGES-1)*WIDTH +: WIDTH];
    assign cout = carry_q[STAGES-1];
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// tb/tb_pipelined_carry_skip_adder.sv - directed and random checks of pipelined_carry_skip_adder
module tb_pipelined_carry_skip_adder;

    logic clk;
    logic rst_n;

    logic [15:0] a16, b16, sum16;
    logic        cin16, sub16, iv16, ir16, cout16, ovf16, ov16, or16;
    logic [63:0] a64, b64, sum64;
    logic        cin64, sub64, iv64, ir64, cout64, ovf64, ov64, or64;
    logic [31:0] a32, b32, sum32;
    logic        cin32, sub32, iv32, ir32, cout32, ovf32, ov32, or32;

    int n_assert = 0;
    int n_fail   = 0;

    localparam int NRAND = 10000;

    pipelined_carry_skip_adder #(.WIDTH(16), .BLK(4), .STAGES(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .in_valid(iv16), .in_ready(ir16), .sum(sum16), .cout(cout16), .ovf(ovf16),
        .out_valid(ov16), .out_ready(or16)
    );

    pipelined_carry_skip_adder #(.WIDTH(64), .BLK(4), .STAGES(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .cin(cin64), .sub(sub64),
        .in_valid(iv64), .in_ready(ir64), .sum(sum64), .cout(cout64), .ovf(ovf64),
        .out_valid(ov64), .out_ready(or64)
    );

    pipelined_carry_skip_adder #(.WIDTH(32), .BLK(8), .STAGES(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .in_valid(iv32), .in_ready(ir32), .sum(sum32), .cout(cout32), .ovf(ovf32),
        .out_valid(ov32), .out_ready(or32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit add/subtract.
    function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input logic s, input int w);
        logic [63:0] m, yy, r;
        logic [64:0] full;
        logic        c_in, co, ov;
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        yy   = (s ? ~y : y) & m;
        c_in = s ? 1'b1 : c;
        full = {1'b0, x & m} + {1'b0, yy} + {64'd0, c_in};
        r    = full[63:0] & m;
        co   = full[w];
        ov   = (x[w-1] == yy[w-1]) && (r[w-1] != x[w-1]);
        return {ov, co, r};
    endfunction

    // Called just after a falling edge; checks latency of exactly two cycles.
    task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s, input logic [15:0] es,
                         input logic ec, input logic eo);
        a16 = x; b16 = y; cin16 = c; sub16 = s; iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        #1;
        chk({tag, "_lat1"}, 66'(ov16), 66'(1'b0));
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, 66'(ov16), 66'(1'b1));
        chk({tag, "_sum"}, 66'(sum16), 66'(es));
        chk({tag, "_cout"}, 66'(cout16), 66'(ec));
        chk({tag, "_ovf"}, 66'(ovf16), 66'(eo));
    endtask

    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        scin [8];
    logic        ssub [8];
    logic [65:0] sexp [8];
    logic [65:0] q64 [$];
    logic [65:0] q32 [$];
    logic [65:0] e;

    initial begin
        int tx, rx, tx64, rx64, tx32, rx32;
        logic stall;

        rst_n = 1'b0;
        a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; iv16 = 0; or16 = 1;
        a64 = '0; b64 = '0; cin64 = 0; sub64 = 0; iv64 = 0; or64 = 1;
        a32 = '0; b32 = '0; cin32 = 0; sub32 = 0; iv32 = 0; or32 = 1;

        @(negedge clk);
        #1;
        chk("rst_out_valid", 66'(ov16), 66'(1'b0));
        chk("rst_sum", 66'(sum16), 66'(16'h0000));
        chk("rst_cout_ovf", 66'({cout16, ovf16}), 66'(2'b00));
        chk("rst_in_ready", 66'({ir16, ir64, ir32}), 66'(3'b111));
        chk("rst_out_valid_others", 66'({ov64, ov32}), 66'(2'b00));

        @(negedge clk);
        rst_n = 1'b1;
        do_op("add_ff_1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("skip_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_borrow", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        do_op("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        // Back-to-back stream with a three-cycle consumer stall; sub/cin vary per op.
        sa   = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'h7FFF, 16'hAAAA, 16'h0F0F, 16'hFFF0};
        sb   = '{16'h0002, 16'h0001, 16'h0001, 16'h1111, 16'h7FFF, 16'h5555, 16'hF0F0, 16'h0010};
        scin = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ssub = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) sexp[i] = model({48'd0, sa[i]}, {48'd0, sb[i]}, scin[i], ssub[i], 16);
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
            @(negedge clk);
            stall = (cyc >= 4) && (cyc <= 6);
            or16  = ~stall;
            iv16  = (tx < 8);
            if (tx < 8) begin
                a16 = sa[tx]; b16 = sb[tx]; cin16 = scin[tx]; sub16 = ssub[tx];
            end
            #1;
            if (stall) begin
                chk("bp_stall_valid", 66'(ov16), 66'(1'b1));
                chk("bp_in_ready", 66'(ir16), 66'(1'b0));
                chk("bp_hold", {ovf16, cout16, 48'd0, sum16}, sexp[rx]);
            end
            if (ov16 && or16) begin
                chk("bp_result", {ovf16, cout16, 48'd0, sum16}, sexp[rx]);
                rx++;
            end
            if (iv16 && ir16) tx++;
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        chk("bp_rx_count", 66'(rx), 66'(8));
        chk("bp_tx_count", 66'(tx), 66'(8));
        @(negedge clk);
        #1;
        chk("bp_no_dup", 66'(ov16), 66'(1'b0));

        // Reset with two operations in flight.
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; sub16 = 0; iv16 = 1'b1;
        @(negedge clk);
        a16 = 16'h3333; b16 = 16'h4444;
        @(negedge clk);
        iv16 = 1'b0;
        #1;
        chk("rst_pre_valid", 66'(ov16), 66'(1'b1));
        chk("rst_pre_sum", 66'(sum16), 66'(16'h3333));
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 66'(ov16), 66'(1'b0));
        chk("rst_async_sum", 66'(sum16), 66'(16'h0000));
        chk("rst_async_in_ready", 66'(ir16), 66'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("rst_no_stale", 66'(ov16), 66'(1'b0));
        end
        do_op("post_rst", 16'hF00F, 16'h0FF1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Random regression on the 64/4/4 and 32/8/1 configurations.
        tx64 = 0; rx64 = 0; tx32 = 0; rx32 = 0;
        for (int cyc = 0; cyc < 60000 && (rx64 < NRAND || rx32 < NRAND); cyc++) begin
            @(negedge clk);
            or64 = ($urandom_range(3) != 0);
            or32 = ($urandom_range(3) != 0);
            iv64 = (tx64 < NRAND) && ($urandom_range(4) != 0);
            a64  = {$urandom(), $urandom()};
            b64  = ($urandom_range(3) == 0) ? ~a64 : {$urandom(), $urandom()};
            cin64 = 1'($urandom_range(1));
            sub64 = 1'($urandom_range(1));
            iv32 = (tx32 < NRAND) && ($urandom_range(4) != 0);
            a32  = $urandom();
            b32  = ($urandom_range(3) == 0) ? ~a32 : $urandom();
            cin32 = 1'($urandom_range(1));
            sub32 = 1'($urandom_range(1));
            #1;
            if (ov64 && or64) begin
                chk("r64_pending", 66'(q64.size() != 0), 66'(1'b1));
                if (q64.size() != 0) begin
                    e = q64.pop_front();
                    chk("r64_result", {ovf64, cout64, sum64}, e);
                end
                rx64++;
            end
            if (iv64 && ir64) begin
                q64.push_back(model(a64, b64, cin64, sub64, 64));
                tx64++;
            end
            if (ov32 && or32) begin
                chk("r32_pending", 66'(q32.size() != 0), 66'(1'b1));
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk("r32_result", {ovf32, cout32, 32'd0, sum32}, e);
                end
                rx32++;
            end
            if (iv32 && ir32) begin
                q32.push_back(model({32'd0, a32}, {32'd0, b32}, cin32, sub32, 32));
                tx32++;
            end
        end
        iv64 = 1'b0;
        iv32 = 1'b0;
        chk("r64_count", 66'(rx64), 66'(NRAND));
        chk("r32_count", 66'(rx32), 66'(NRAND));
        chk("r64_drained", 66'(q64.size()), 66'(0));
        chk("r32_drained", 66'(q32.size()), 66'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
